// File: rtl/freq_seq_pkg.sv
// freq_seq_pkg
// Shared types and constants for the sequencer frequency-store reader.
// - freq_t      : unsigned fixed-point frequency word, INT_W.FRAC_W (440.0 Hz = 20'h01B80)
// - seq_state_t : reader FSM states
// - MIN_STEP_LEN: shortest step the FSM can walk (FETCH, CAPTURE, PRESENT, WAIT)
package freq_seq_pkg;

    localparam int FREQ_W       = 20;
    localparam int FRAC_W       = 4;
    localparam int INT_W        = FREQ_W - FRAC_W;
    localparam int MIN_STEP_LEN = 4;

    typedef logic [FREQ_W-1:0] freq_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        PRESENT,
        WAIT
    } seq_state_t;

endpackage : freq_seq_pkg

// File: rtl/step_tempo_counter.sv
// step_tempo_counter
// Per-step tempo counter: cleared at the start of every step, counts up while
// enabled and sticks at all-ones instead of wrapping.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force count to 0 on the next edge (wins over enable)
//   enable    : increment on the next edge
//   period    : sampled step period in clocks (values below MIN_STEP_LEN act as MIN_STEP_LEN)
//   expired   : count >= effective period - 1
//   at_term   : count == effective period - 1 (true for exactly one cycle per step)
module step_tempo_counter
    import freq_seq_pkg::*;
#(
    parameter int TEMPO_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [TEMPO_W-1:0] period,
    output logic               expired,
    output logic               at_term
);

    logic [TEMPO_W-1:0] count;
    logic [TEMPO_W-1:0] limit;

    // The FSM needs four cycles per step, so shorter periods are stretched.
    always_comb begin
        limit = period - TEMPO_W'(1);
        if (period < TEMPO_W'(MIN_STEP_LEN)) begin
            limit = TEMPO_W'(MIN_STEP_LEN - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TEMPO_W'(1);
        end
    end

    assign expired = (count >= limit);
    assign at_term = (count == limit);

endmodule : step_tempo_counter

// File: rtl/freq_seq_reader.sv
// freq_seq_reader
// Read side of the sequencer frequency store. Walks step slots 0..LAST_STEP,
// fetches each frequency word and offers it to the oscillator on a
// valid/ready handshake, one step every max(STEP_PERIOD, 4) clocks.
// Optional build macro: FREQ_SEQ_REST_EN -- a captured word of zero is a rest:
// nothing is presented for that step and FREQ_OUT keeps its previous value.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   RUN          : 1 = sequence running, 0 = stop
//   STEP_PERIOD  : clocks per step (sampled in FETCH)
//   LAST_STEP    : last slot before wrapping to 0 (sampled in FETCH, clamped to NUM_STEPS-1)
//   RD_ADDR      : slot address to the store
//   RD_DATA      : store data, valid one cycle after RD_ADDR
//   FREQ_OUT     : frequency word to the oscillator
//   FREQ_VALID   : FREQ_OUT valid
//   FREQ_READY   : oscillator accepts FREQ_OUT
//   STEP_IDX     : current step
//   BUSY         : FSM not in IDLE
//   OVERRUN      : one-cycle pulse when the step period runs out while still presenting
//
// state   | meaning
// IDLE    | stopped, STEP_IDX held at 0, FREQ_OUT keeps last value
// FETCH   | slot address on RD_ADDR, tempo count 0, period/last step sampled
// CAPTURE | store data registered into FREQ_OUT, FREQ_VALID raised
// PRESENT | FREQ_VALID high until the oscillator takes the word
// WAIT    | waiting for the tempo counter to finish the step
module freq_seq_reader
    import freq_seq_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int TEMPO_W   = 24,
    parameter int ADDR_W    = $clog2(NUM_STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RUN,
    input  logic [TEMPO_W-1:0] STEP_PERIOD,
    input  logic [ADDR_W-1:0]  LAST_STEP,
    output logic [ADDR_W-1:0]  RD_ADDR,
    input  logic [FREQ_W-1:0]  RD_DATA,
    output logic [FREQ_W-1:0]  FREQ_OUT,
    output logic               FREQ_VALID,
    input  logic               FREQ_READY,
    output logic [ADDR_W-1:0]  STEP_IDX,
    output logic               BUSY,
    output logic               OVERRUN
);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [ADDR_W-1:0]  step_idx;
    logic [ADDR_W-1:0]  step_next;
    logic [ADDR_W-1:0]  step_adv;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  last_q;
    logic [ADDR_W-1:0]  last_clamped;
    logic [TEMPO_W-1:0] period_q;
    freq_t              freq_out;
    logic               freq_valid;
    logic               valid_next;
    logic               capture_en;
    logic               handshake;
    logic               rest_word;
    logic               cnt_clear;
    logic               cnt_en;
    logic               expired;
    logic               at_term;

    assign handshake = freq_valid & FREQ_READY;

`ifdef FREQ_SEQ_REST_EN
    assign rest_word = (RD_DATA == '0);
`else
    assign rest_word = 1'b0;
`endif

    always_comb begin
        last_clamped = LAST_STEP;
        if (int'(LAST_STEP) >= NUM_STEPS) begin
            last_clamped = ADDR_W'(NUM_STEPS - 1);
        end
    end

    // ">=" rather than "==" so a LAST_STEP lowered mid-run still wraps.
    assign step_adv = (step_idx >= last_q) ? '0 : step_idx + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step_idx;
        valid_next = freq_valid;
        capture_en = 1'b0;
        case (state)
            IDLE: begin
                step_next = '0;
                if (RUN) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (!RUN) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!RUN) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else if (rest_word) begin
                    state_next = WAIT;
                end else begin
                    capture_en = 1'b1;
                    valid_next = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    valid_next = 1'b0;
                    if (!RUN) begin
                        state_next = IDLE;
                        step_next  = '0;
                    end else if (expired) begin
                        // Late handshake: the step is already due, skip WAIT.
                        state_next = FETCH;
                        step_next  = step_adv;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!RUN) begin
                    state_next = IDLE;
                    step_next  = '0;
                end else if (expired) begin
                    state_next = FETCH;
                    step_next  = step_adv;
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_idx   <= '0;
            rd_addr    <= '0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            period_q   <= '0;
            last_q     <= '0;
        end else begin
            step_idx   <= step_next;
            freq_valid <= valid_next;
            if (capture_en) begin
                freq_out <= RD_DATA;
            end
            // Address is launched on entry to FETCH so the store's registered
            // read data is on RD_DATA during CAPTURE.
            if (state_next == FETCH) begin
                rd_addr <= step_next;
            end
            if (state == FETCH) begin
                period_q <= STEP_PERIOD;
                last_q   <= last_clamped;
            end
        end
    end

    // Count is 0 during FETCH, so FETCH-to-FETCH spacing equals the step length.
    assign cnt_clear = (state_next == FETCH) || (state_next == IDLE);
    assign cnt_en    = (state != IDLE);

    step_tempo_counter #(
        .TEMPO_W (TEMPO_W)
    ) u_tempo (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .period  (period_q),
        .expired (expired),
        .at_term (at_term)
    );

    assign RD_ADDR    = rd_addr;
    assign FREQ_OUT   = freq_out;
    assign FREQ_VALID = freq_valid;
    assign STEP_IDX   = step_idx;
    assign BUSY       = (state != IDLE);
    assign OVERRUN    = (state == PRESENT) && at_term;

endmodule : freq_seq_reader

// File: tb/tb_freq_seq_reader.sv
// tb_freq_seq_reader
// Directed bench for freq_seq_reader. dut_a uses NUM_STEPS=8, dut_b uses
// NUM_STEPS=6; both share clock, reset, tempo inputs and FREQ_READY.
// Honours FREQ_SEQ_REST_EN for the zero-word slot expectations.
module tb_freq_seq_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        run_b;
    logic        ready;
    logic [23:0] step_period;
    logic [2:0]  last_step;

    logic [2:0]  rd_addr_a, rd_addr_b;
    logic [19:0] rd_data_a, rd_data_b;
    logic [19:0] freq_out_a, freq_out_b;
    logic        valid_a, valid_b;
    logic [2:0]  step_a, step_b;
    logic        busy_a, busy_b;
    logic        overrun_a, overrun_b;

    logic [19:0] mem_a [8];
    logic [19:0] mem_b [8];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data_a <= mem_a[rd_addr_a];
        rd_data_b <= mem_b[rd_addr_b];
    end

    freq_seq_reader #(.NUM_STEPS(8), .TEMPO_W(24)) dut_a (
        .clk(clk), .rst(rst), .RUN(run), .STEP_PERIOD(step_period), .LAST_STEP(last_step),
        .RD_ADDR(rd_addr_a), .RD_DATA(rd_data_a), .FREQ_OUT(freq_out_a), .FREQ_VALID(valid_a),
        .FREQ_READY(ready), .STEP_IDX(step_a), .BUSY(busy_a), .OVERRUN(overrun_a)
    );

    freq_seq_reader #(.NUM_STEPS(6), .TEMPO_W(24)) dut_b (
        .clk(clk), .rst(rst), .RUN(run_b), .STEP_PERIOD(step_period), .LAST_STEP(last_step),
        .RD_ADDR(rd_addr_b), .RD_DATA(rd_data_b), .FREQ_OUT(freq_out_b), .FREQ_VALID(valid_b),
        .FREQ_READY(ready), .STEP_IDX(step_b), .BUSY(busy_b), .OVERRUN(overrun_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " rd_addr"},  32'(rd_addr_a),  32'd0);
        check({tag, " freq_out"}, 32'(freq_out_a), 32'd0);
        check({tag, " valid"},    32'(valid_a),    32'd0);
        check({tag, " step"},     32'(step_a),     32'd0);
        check({tag, " busy"},     32'(busy_a),     32'd0);
        check({tag, " overrun"},  32'(overrun_a),  32'd0);
    endtask

    initial begin
        bit rest;
`ifdef FREQ_SEQ_REST_EN
        rest = 1'b1;
`else
        rest = 1'b0;
`endif
        mem_a[0] = 20'h01B80;
        mem_a[1] = 20'h00DC0;
        mem_a[2] = 20'h02930;
        mem_a[3] = 20'h00000;
        for (int i = 4; i < 8; i++) mem_a[i] = 20'h01000 + 20'(i);
        for (int i = 0; i < 8; i++) mem_b[i] = 20'h00100 + 20'(i);

        rst = 1'b1; run = 1'b0; run_b = 1'b0; ready = 1'b0;
        step_period = 24'd10; last_step = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_a("init");
        check("init b busy", 32'(busy_b), 32'd0);
        check("init b step", 32'(step_b), 32'd0);

        // Reach PRESENT with READY low, then reset for two cycles.
        rst = 1'b0; run = 1'b1;
        repeat (3) @(negedge clk);
        check("pre-rst valid", 32'(valid_a),    32'd1);
        check("pre-rst freq",  32'(freq_out_a), 32'h01B80);
        check("pre-rst busy",  32'(busy_a),     32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_a("rst edge1");
        @(negedge clk);
        check_reset_a("rst edge2");

        // Free run, READY high: VALID every 10 clocks, slots 0..3 then wrap.
        ready = 1'b1; rst = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            bit vexp;
            int slot;
            @(negedge clk);
            slot = (k >= 3) ? ((k - 3) / 10) % 4 : 0;
            vexp = (k >= 3) && ((k - 3) % 10 == 0) && !(rest && slot == 3);
            check($sformatf("run valid k=%0d", k), 32'(valid_a), 32'(vexp));
            check($sformatf("run overrun k=%0d", k), 32'(overrun_a), 32'd0);
            if (vexp) begin
                check($sformatf("run freq k=%0d", k), 32'(freq_out_a), 32'(mem_a[slot]));
                check($sformatf("run step k=%0d", k), 32'(step_a), 32'(slot));
            end
            if (k >= 34 && k <= 42)
                check($sformatf("slot3 hold k=%0d", k), 32'(freq_out_a),
                      rest ? 32'h02930 : 32'h0);
        end

        // Backpressure at step 1, then drop RUN in WAIT of step 2.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ready = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k >= 13 && k <= 28) begin
                check($sformatf("bp valid k=%0d", k), 32'(valid_a),    32'd1);
                check($sformatf("bp freq k=%0d", k),  32'(freq_out_a), 32'h00DC0);
            end
            check($sformatf("bp overrun k=%0d", k), 32'(overrun_a), 32'(k == 20));
            if (k == 28) check("bp step before hs", 32'(step_a), 32'd1);
            if (k == 29) begin
                check("late fetch step",  32'(step_a),    32'd2);
                check("late fetch addr",  32'(rd_addr_a), 32'd2);
                check("late fetch valid", 32'(valid_a),   32'd0);
                check("late fetch busy",  32'(busy_a),    32'd1);
            end
            if (k == 31) begin
                check("step2 valid", 32'(valid_a),    32'd1);
                check("step2 freq",  32'(freq_out_a), 32'h02930);
            end
            if (k == 32) check("step2 wait busy", 32'(busy_a), 32'd1);
            if (k == 34) begin
                check("stop busy",  32'(busy_a),  32'd0);
                check("stop step",  32'(step_a),  32'd0);
                check("stop valid", 32'(valid_a), 32'd0);
            end
            if (k == 4)  ready = 1'b0;
            if (k == 28) ready = 1'b1;
            if (k == 33) run = 1'b0;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("idle valid k=%0d", k), 32'(valid_a),    32'd0);
            check($sformatf("idle busy k=%0d", k),  32'(busy_a),     32'd0);
            check($sformatf("idle freq k=%0d", k),  32'(freq_out_a), 32'h02930);
        end

        // Short period, LAST_STEP=7 on both: wraps at 7 and at clamped 5.
        rst = 1'b1; step_period = 24'd2; last_step = 3'd7; ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; run = 1'b1; run_b = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            check($sformatf("wrap8 step k=%0d", k), 32'(step_a), 32'(((k - 1) / 4) % 8));
            check($sformatf("wrap6 step k=%0d", k), 32'(step_b), 32'(((k - 1) / 4) % 6));
            check($sformatf("wrap ovr k=%0d", k), 32'({overrun_a, overrun_b}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_freq_seq_reader
